// File: rtl/aes_cmd_sequencer.sv
// Host command sequencer for an AES-256 key-expansion/cipher core pair.
// Accepts one command at a time, drives the key or cipher bus, returns one response.
module aes_cmd_sequencer #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [255:0] cmd_key,
  input  logic [127:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [255:0] i_key,
  output logic [1:0]   i_key_mode,
  output logic         i_start,
  input  logic         o_key_ready,
  output logic [127:0] i_data,
  output logic         i_data_valid,
  output logic         i_ende,
  output logic         i_enable,
  input  logic         o_ready,
  input  logic [127:0] o_data,
  input  logic         o_data_valid
);
  localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, KEY_START, KEY_WAIT, DATA_WAIT_RDY, DATA_ISSUE, DATA_WAIT_OUT, RSP
  } state_t;

  typedef struct packed {
    logic         vld;
    logic         err;
    logic [127:0] data;
  } rsp_t;

  localparam rsp_t RSP_ERR = '{vld: 1'b1, err: 1'b1, data: '0};

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic          key_loaded, key_loaded_n;
  rsp_t          rsp_q, rsp_n;
  logic          cmd_ready_n, i_start_n, i_data_valid_n, i_ende_n, i_enable_n;
  logic [1:0]    i_key_mode_n;
  logic [255:0]  i_key_n;
  logic [127:0]  i_data_n;
  logic          timed_out, in_wait;

  assign rsp_valid = rsp_q.vld;
  assign rsp_err   = rsp_q.err;
  assign rsp_data  = rsp_q.data;

  // Counter value CNT_LAST means TIMEOUT cycles have been spent in this wait state.
  assign timed_out = (wait_cnt == CNT_LAST);
  assign in_wait   = (state == KEY_WAIT) || (state == DATA_WAIT_RDY) || (state == DATA_WAIT_OUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      key_loaded   <= 1'b0;
      rsp_q        <= '0;
      cmd_ready    <= 1'b0;
      i_key        <= '0;
      i_key_mode   <= 2'b00;
      i_start      <= 1'b0;
      i_data       <= '0;
      i_data_valid <= 1'b0;
      i_ende       <= 1'b0;
      i_enable     <= 1'b0;
    end else begin
      state        <= state_n;
      wait_cnt     <= wait_cnt_n;
      key_loaded   <= key_loaded_n;
      rsp_q        <= rsp_n;
      cmd_ready    <= cmd_ready_n;
      i_key        <= i_key_n;
      i_key_mode   <= i_key_mode_n;
      i_start      <= i_start_n;
      i_data       <= i_data_n;
      i_data_valid <= i_data_valid_n;
      i_ende       <= i_ende_n;
      i_enable     <= i_enable_n;
    end
  end

  // Next values of every output register are computed here so all outputs come from flops.
  always_comb begin
    state_n        = state;
    key_loaded_n   = key_loaded;
    rsp_n          = rsp_q;
    i_key_n        = i_key;
    i_key_mode_n   = 2'b00;
    i_start_n      = 1'b0;
    i_data_n       = i_data;
    i_data_valid_n = 1'b0;
    i_ende_n       = i_ende;
    i_enable_n     = i_enable;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          unique case (cmd_op)
            2'b00: begin
              key_loaded_n = 1'b0;
              i_key_n      = cmd_key;
              i_key_mode_n = 2'b10;
              i_start_n    = 1'b1;
              state_n      = KEY_START;
            end
            2'b01, 2'b10: begin
              if (key_loaded) begin
                i_data_n = cmd_data;
                i_ende_n = cmd_op[1];
                state_n  = DATA_WAIT_RDY;
              end else begin
                rsp_n   = RSP_ERR;
                state_n = RSP;
              end
            end
            default: begin
              rsp_n   = RSP_ERR;
              state_n = RSP;
            end
          endcase
        end
      end
      KEY_START: state_n = KEY_WAIT;
      KEY_WAIT: begin
        if (o_key_ready) begin
          key_loaded_n = 1'b1;
          rsp_n        = '{vld: 1'b1, err: 1'b0, data: '0};
          state_n      = RSP;
        end else if (timed_out) begin
          key_loaded_n = 1'b0;
          rsp_n        = RSP_ERR;
          state_n      = RSP;
        end
      end
      DATA_WAIT_RDY: begin
        if (o_ready) begin
          i_data_valid_n = 1'b1;
          i_enable_n     = 1'b1;
          state_n        = DATA_ISSUE;
        end else if (timed_out) begin
          i_enable_n = 1'b0;
          rsp_n      = RSP_ERR;
          state_n    = RSP;
        end
      end
      DATA_ISSUE: state_n = DATA_WAIT_OUT;
      DATA_WAIT_OUT: begin
        if (o_data_valid) begin
          i_enable_n = 1'b0;
          rsp_n      = '{vld: 1'b1, err: 1'b0, data: o_data};
          state_n    = RSP;
        end else if (timed_out) begin
          i_enable_n = 1'b0;
          rsp_n      = RSP_ERR;
          state_n    = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_n.vld = 1'b0;
          i_ende_n  = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    cmd_ready_n = (state_n == IDLE);
    if (state_n != state)
      wait_cnt_n = '0;
    else if (in_wait)
      wait_cnt_n = wait_cnt + 1'b1;
    else
      wait_cnt_n = '0;
  end
endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer with behavioural key/cipher core models.
module tb_aes_cmd_sequencer;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [255:0] cmd_key = '0;
  logic [127:0] cmd_data = '0;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [127:0] rsp_data;
  logic [255:0] i_key;
  logic [1:0]   i_key_mode;
  logic         i_start, o_key_ready = 1'b0;
  logic [127:0] i_data, o_data = '0;
  logic         i_data_valid, i_ende, i_enable, o_ready = 1'b1, o_data_valid = 1'b0;

  int checks = 0, errors = 0;
  int n_start = 0, n_dv = 0, n_rspv = 0;
  int cyc, base_start, base_dv, base_rspv;

  aes_cmd_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .i_key(i_key), .i_key_mode(i_key_mode),
    .i_start(i_start), .o_key_ready(o_key_ready), .i_data(i_data), .i_data_valid(i_data_valid),
    .i_ende(i_ende), .i_enable(i_enable), .o_ready(o_ready), .o_data(o_data),
    .o_data_valid(o_data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] kat(input logic [127:0] d, input logic dec);
    if (!dec && d == PT) return CT;
    if (dec && d == CT)  return PT;
    return 128'hdeadbeef;
  endfunction

  // Key core: o_key_ready pulses in the 14th cycle after the i_start cycle.
  initial begin
    int kc = 0;
    logic s;
    forever begin
      @(posedge clk);
      s = i_start;
      #1;
      o_key_ready = 1'b0;
      if (s) kc = 1;
      else if (kc != 0) begin
        kc++;
        if (kc == 14) begin
          o_key_ready = 1'b1;
          kc = 0;
        end
      end
    end
  end

  // Cipher core: result pulse three cycles after the i_data_valid cycle ends.
  initial begin
    int dc = 0;
    logic v, e;
    logic [127:0] d, res;
    res = '0;
    forever begin
      @(posedge clk);
      v = i_data_valid; d = i_data; e = i_ende;
      #1;
      o_data_valid = 1'b0;
      if (v) begin
        dc = 3;
        res = kat(d, e);
      end else if (dc != 0) begin
        dc--;
        if (dc == 0) begin
          o_data_valid = 1'b1;
          o_data = res;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (i_start) n_start++;
      if (i_data_valid) n_dv++;
      if (rsp_valid) n_rspv++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [1:0] op, input logic [255:0] k, input logic [127:0] d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("cmd_ready_wait", 256'(n), 256'(0));
    cmd_op = op; cmd_key = k; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int c);
    c = 0;
    while (!rsp_valid && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #12;
    chk("rst_ctrl", {cmd_ready, rsp_valid, rsp_err, i_key_mode, i_start, i_data_valid, i_ende, i_enable}, '0);
    chk("rst_buses", {rsp_data, i_data}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_rel_ready0", cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_rel_ready1", cmd_ready, 1'b1);

    // Key load
    base_start = n_start;
    send(2'b00, KEY, '0);
    chk("key_start", i_start, 1'b1);
    chk("key_mode", i_key_mode, 2'b10);
    chk("key_bus", i_key, KEY);
    chk("key_busy", cmd_ready, 1'b0);
    wait_rsp(cyc);
    chk("key_latency", cyc, 15);
    chk("key_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 128'h0});
    chk("key_start_len", n_start - base_start, 1);
    ack();
    chk("key_ack", {rsp_valid, cmd_ready}, 2'b01);

    // Encrypt
    base_dv = n_dv;
    send(2'b01, '0, PT);
    chk("enc_ende", {i_ende, i_data_valid}, 2'b00);
    @(posedge clk); #1;
    chk("enc_issue", {i_data_valid, i_enable}, 2'b11);
    chk("enc_data", i_data, PT);
    @(posedge clk); #1;
    chk("enc_dv_off", {i_data_valid, i_enable}, 2'b01);
    wait_rsp(cyc);
    chk("enc_latency", cyc, 4);
    chk("enc_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, CT});
    chk("enc_en_off", {i_enable, i_ende}, 2'b00);
    chk("enc_dv_len", n_dv - base_dv, 1);
    ack();

    // Decrypt
    send(2'b10, '0, CT);
    chk("dec_ende", i_ende, 1'b1);
    wait_rsp(cyc);
    chk("dec_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, PT});
    chk("dec_ende_held", i_ende, 1'b1);
    ack();

    // No key after reset, then illegal op
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    base_start = n_start; base_dv = n_dv;
    send(2'b01, '0, PT);
    chk("nokey_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 128'h0});
    ack();
    send(2'b11, '0, PT);
    chk("illegal_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 128'h0});
    ack();
    repeat (3) @(posedge clk);
    #1;
    chk("err_no_bus", {32'(n_start - base_start), 32'(n_dv - base_dv)}, '0);

    // Timeout in DATA_WAIT_RDY
    send(2'b00, KEY, '0);
    wait_rsp(cyc);
    chk("rekey_rsp", {rsp_valid, rsp_err}, 2'b10);
    ack();
    o_ready = 1'b0;
    base_dv = n_dv;
    send(2'b01, '0, PT);
    wait_rsp(cyc);
    chk("to_latency", cyc, 15);
    chk("to_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 128'h0});
    chk("to_no_issue", {i_enable, 32'(n_dv - base_dv)}, '0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("to_hold", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 128'h0});
    end
    ack();
    chk("to_ack", {rsp_valid, cmd_ready}, 2'b01);
    o_ready = 1'b1;

    // Reset during DATA_WAIT_OUT
    send(2'b10, '0, CT);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_pre", {i_enable, i_ende}, 2'b11);
    #2;
    reset = 1'b1;
    base_rspv = n_rspv;
    #1;
    chk("rst_mid_ctrl", {cmd_ready, rsp_valid, rsp_err, i_key_mode, i_start, i_data_valid, i_ende, i_enable}, '0);
    chk("rst_mid_key", i_key, '0);
    chk("rst_mid_buses", {rsp_data, i_data}, '0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_rsp", n_rspv - base_rspv, 0);
    send(2'b01, '0, PT);
    chk("rst_key_cleared", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 128'h0});
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
